hpi_bus_master: RTL and testbench
=================================

HPI_BUS_MASTER -- requirements
Module: hpi_bus_master

Interface
REQ-001 Parameters SHALL be: DATA_W, default 16, HPI data width; ADDR_W, default 2, HPI address width; SETUP_CYC, default 1, cycles of CS_N/address/data before strobe; STROBE_CYC, default 2, RD_N/WR_N low cycles; HOLD_CYC, default 1, cycles after strobe release; RST_CYC, default 4, soft-reset pulse length. All cycle parameters SHALL be at least 1.
REQ-002 Clk  in  1  single clock, all logic rising-edge.
REQ-003 Reset_N  in  1  asynchronous, active-low reset.
REQ-004 req  in  1  transaction request, sampled in IDLE only.
REQ-005 we  in  1  1=write, 0=read, qualified by req.
REQ-006 addr  in  ADDR_W  HPI register address, qualified by req.
REQ-007 wdata  in  DATA_W  write data, qualified by req.
REQ-008 soft_rst  in  1  request for an HPI chip reset pulse.
REQ-009 busy  out  1  high in every state except IDLE.
REQ-010 ack  out  1  one-cycle pulse when a transaction completes.
REQ-011 rdata  out  DATA_W  read data, valid from ack until the next read ack.
REQ-012 irq_level  out  1  synchronised OTG_INT.
REQ-013 irq_pulse  out  1  one-cycle pulse on a rising edge of irq_level.
REQ-014 OTG_DATA  inout  DATA_W  HPI data bus.
REQ-015 OTG_ADDR  out  ADDR_W; OTG_CS_N, OTG_RD_N, OTG_WR_N, OTG_RST_N  out  1 each; OTG_INT  in  1.

Function
REQ-016 The FSM SHALL have the states IDLE, SETUP, STROBE, HOLD and RST.
REQ-017 In IDLE with req=1 and soft_rst=0, the block SHALL register we, addr and wdata and enter SETUP on the next edge.
REQ-018 In IDLE with soft_rst=1, the block SHALL enter RST. If req is also high, soft_rst SHALL win and the req SHALL be dropped with no ack.
REQ-019 req and soft_rst SHALL be ignored while busy=1.
REQ-020 SETUP SHALL last SETUP_CYC cycles, STROBE SHALL last STROBE_CYC cycles and HOLD SHALL last HOLD_CYC cycles. One down-counter reloaded on each state entry SHALL time all three states.
REQ-021 OTG_CS_N SHALL be low and OTG_ADDR SHALL equal the registered address throughout SETUP, STROBE and HOLD.
REQ-022 OTG_RD_N (read) or OTG_WR_N (write) SHALL be low only during STROBE; both SHALL be high in every other state.
REQ-023 OTG_DATA SHALL be driven with registered wdata only during SETUP, STROBE and HOLD of a write, and SHALL be high-Z at all other times, including during reset.
REQ-024 A read SHALL register OTG_DATA into rdata on the clock edge that ends the last STROBE cycle.
REQ-025 ack SHALL pulse in the first cycle after HOLD (back in IDLE). Latency from the req-sampling edge to ack high SHALL be 1+SETUP_CYC+STROBE_CYC+HOLD_CYC cycles, which is 5 with the defaults.
REQ-026 A new req SHALL be accepted in the same cycle that ack is high (back-to-back transactions).
REQ-027 In RST, OTG_RST_N SHALL be low for exactly RST_CYC cycles, then the FSM SHALL return to IDLE. No ack SHALL be issued for a soft reset.
REQ-028 OTG_RST_N SHALL be low whenever Reset_N is low or the FSM is in RST, and high otherwise.
REQ-029 OTG_INT SHALL pass through a 2-flop synchroniser to form irq_level. irq_pulse SHALL be irq_level AND NOT its previous value.
REQ-030 All outputs except OTG_RST_N and OTG_DATA SHALL be registered.

Reset
REQ-031 While Reset_N is low, the block SHALL hold: state=IDLE, counter=0, busy=0, ack=0, rdata=0, OTG_CS_N=OTG_RD_N=OTG_WR_N=1, OTG_ADDR=0, OTG_DATA high-Z, OTG_RST_N=0, synchroniser flops=0, irq_level=irq_pulse=0.
REQ-032 Reset_N asserting mid-transaction SHALL abort it immediately and asynchronously, with no ack, and SHALL return every output to its reset value.

Structure
REQ-033 Package hpi_pkg SHALL hold the state enum and the default parameter constants.
REQ-034 The synchroniser and edge detector SHALL be sub-module hpi_int_sync, instantiated once.

Verification
REQ-035 Write: req=1, we=1, addr=2, wdata=16'hA5A5 (defaults) -> CS_N low for 4 cycles, WR_N low for cycles 2-3 of that window, OTG_DATA=A5A5 for those 4 cycles, ack 5 cycles after the req edge.
REQ-036 Read: model drives 16'h1234 during STROBE, addr=1 -> RD_N low for 2 cycles, WR_N stays high, rdata=16'h1234 at ack, OTG_DATA high-Z throughout.
REQ-037 Back-to-back: req held high for a write and then a read -> second CS_N window starts the cycle after ack, no idle gap beyond the IDLE cycle.
REQ-038 soft_rst and req in the same IDLE cycle -> OTG_RST_N low for 4 cycles, busy high for 4 cycles, no CS_N activity, no ack.
REQ-039 Reset_N asserted during STROBE of a write -> RD_N/WR_N/CS_N high and OTG_DATA high-Z in the same cycle, no ack after release.
REQ-040 OTG_INT rising, held 10 cycles -> irq_level high 2 cycles later, exactly one irq_pulse.

Source files
------------

// File: rtl/hpi_pkg.sv
// Shared types and default timing constants for the HPI bus master.
package hpi_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StStrobe,
    StHold,
    StRst
  } hpi_state_e;

  localparam int unsigned DefDataW     = 16;
  localparam int unsigned DefAddrW     = 2;
  localparam int unsigned DefSetupCyc  = 1;
  localparam int unsigned DefStrobeCyc = 2;
  localparam int unsigned DefHoldCyc   = 1;
  localparam int unsigned DefRstCyc    = 4;

  // Phase counter width; every cycle parameter must fit in it.
  localparam int unsigned CntW = 8;

endpackage

// File: rtl/hpi_int_sync.sv
// Two-flop synchroniser for OTG_INT plus registered rising-edge pulse.
module hpi_int_sync (
  input  logic Clk,
  input  logic Reset_N,
  input  logic int_i,
  output logic level_o,
  output logic pulse_o
);

  logic meta_q, sync_q, pulse_q;

  // pulse_q rises on the same edge as sync_q, so it equals level & ~previous level.
  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      meta_q  <= int_i;
      sync_q  <= meta_q;
      pulse_q <= meta_q & ~sync_q;
    end
  end

  assign level_o = sync_q;
  assign pulse_o = pulse_q;

endmodule

// File: rtl/hpi_bus_master.sv
// HPI host-port bus master: timed CS/RD/WR cycles, soft chip reset, interrupt sync.
module hpi_bus_master
  import hpi_pkg::*;
#(
  parameter int unsigned DATA_W     = DefDataW,
  parameter int unsigned ADDR_W     = DefAddrW,
  parameter int unsigned SETUP_CYC  = DefSetupCyc,
  parameter int unsigned STROBE_CYC = DefStrobeCyc,
  parameter int unsigned HOLD_CYC   = DefHoldCyc,
  parameter int unsigned RST_CYC    = DefRstCyc
) (
  input  logic              Clk,
  input  logic              Reset_N,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              soft_rst,
  output logic              busy,
  output logic              ack,
  output logic [DATA_W-1:0] rdata,
  output logic              irq_level,
  output logic              irq_pulse,
  inout  logic [DATA_W-1:0] OTG_DATA,
  output logic [ADDR_W-1:0] OTG_ADDR,
  output logic              OTG_CS_N,
  output logic              OTG_RD_N,
  output logic              OTG_WR_N,
  output logic              OTG_RST_N,
  input  logic              OTG_INT
);

  hpi_state_e        state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              load, cnt_zero, strobe_end, in_xfer_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rdata_q;
  logic              cs_n_q, rd_n_q, wr_n_q, drive_q, busy_q, ack_q;

  assign cnt_zero   = (cnt_q == '0);
  assign strobe_end = (state_q == StStrobe) && cnt_zero;

  // One down-counter, reloaded with (length - 1) on every state entry.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_zero ? cnt_q : cnt_q - CntW'(1);
    load    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (soft_rst) begin
          state_d = StRst;
          cnt_d   = CntW'(RST_CYC - 1);
        end else if (req) begin
          load    = 1'b1;
          state_d = StSetup;
          cnt_d   = CntW'(SETUP_CYC - 1);
        end
      end
      StSetup: begin
        if (cnt_zero) begin
          state_d = StStrobe;
          cnt_d   = CntW'(STROBE_CYC - 1);
        end
      end
      StStrobe: begin
        if (cnt_zero) begin
          state_d = StHold;
          cnt_d   = CntW'(HOLD_CYC - 1);
        end
      end
      StHold:  if (cnt_zero) state_d = StIdle;
      StRst:   if (cnt_zero) state_d = StIdle;
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  assign we_d      = load ? we : we_q;
  assign in_xfer_d = (state_d == StSetup) || (state_d == StStrobe) || (state_d == StHold);

  // Bus outputs are decoded from the next state so they are true flops.
  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cs_n_q  <= 1'b1;
      rd_n_q  <= 1'b1;
      wr_n_q  <= 1'b1;
      drive_q <= 1'b0;
      busy_q  <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      if (load) begin
        addr_q  <= addr;
        wdata_q <= wdata;
      end
      if (strobe_end && !we_q) rdata_q <= OTG_DATA;
      cs_n_q  <= !in_xfer_d;
      rd_n_q  <= !((state_d == StStrobe) && !we_d);
      wr_n_q  <= !((state_d == StStrobe) && we_d);
      drive_q <= in_xfer_d && we_d;
      busy_q  <= (state_d != StIdle);
      ack_q   <= (state_q == StHold) && cnt_zero;
    end
  end

  assign OTG_DATA  = drive_q ? wdata_q : {DATA_W{1'bz}};
  assign OTG_ADDR  = addr_q;
  assign OTG_CS_N  = cs_n_q;
  assign OTG_RD_N  = rd_n_q;
  assign OTG_WR_N  = wr_n_q;
  assign OTG_RST_N = Reset_N && (state_q != StRst);
  assign busy      = busy_q;
  assign ack       = ack_q;
  assign rdata     = rdata_q;

  hpi_int_sync u_int_sync (
    .Clk     (Clk),
    .Reset_N (Reset_N),
    .int_i   (OTG_INT),
    .level_o (irq_level),
    .pulse_o (irq_pulse)
  );

endmodule

// File: tb/tb_hpi_bus_master.sv
// Randomised self-checking bench for hpi_bus_master with a memory-backed HPI slave model.
module tb_hpi_bus_master;

  localparam int unsigned DW  = 16;
  localparam int unsigned AW  = 2;
  localparam int unsigned SC  = 1;
  localparam int unsigned STC = 2;
  localparam int unsigned HC  = 1;
  localparam int unsigned RC  = 4;
  localparam int ExpLat = 1 + SC + STC + HC;
  localparam int ExpCs  = SC + STC + HC;

  logic          Clk = 1'b0;
  logic          Reset_N;
  logic          req, we, soft_rst, otg_int;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          busy, ack, irq_level, irq_pulse;
  logic [DW-1:0] rdata;
  wire  [DW-1:0] otg_data;
  logic [AW-1:0] otg_addr;
  logic          cs_n, rd_n, wr_n, rst_n;

  logic [DW-1:0] slave_mem [4] = '{default: '0};
  logic [DW-1:0] exp_mem [4];
  int vectors = 0;
  int miscompares = 0;

  always #5 Clk = ~Clk;

  hpi_bus_master #(
    .DATA_W     (DW),
    .ADDR_W     (AW),
    .SETUP_CYC  (SC),
    .STROBE_CYC (STC),
    .HOLD_CYC   (HC),
    .RST_CYC    (RC)
  ) dut (
    .Clk       (Clk),
    .Reset_N   (Reset_N),
    .req       (req),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
    .soft_rst  (soft_rst),
    .busy      (busy),
    .ack       (ack),
    .rdata     (rdata),
    .irq_level (irq_level),
    .irq_pulse (irq_pulse),
    .OTG_DATA  (otg_data),
    .OTG_ADDR  (otg_addr),
    .OTG_CS_N  (cs_n),
    .OTG_RD_N  (rd_n),
    .OTG_WR_N  (wr_n),
    .OTG_RST_N (rst_n),
    .OTG_INT   (otg_int)
  );

  // Slave: returns its register while read-strobed, captures data while write-strobed.
  assign otg_data = (!cs_n && !rd_n) ? slave_mem[otg_addr] : {DW{1'bz}};
  always @(posedge Clk) if (!cs_n && !wr_n) slave_mem[otg_addr] <= otg_data;

  // Undriven reads as X/Z in 4-state simulators and as zero in 2-state ones.
  function automatic bit released();
    return $isunknown(otg_data) || (otg_data == '0);
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic run_txn(input logic t_we, input logic [AW-1:0] t_addr,
                         input logic [DW-1:0] t_wdata, input bit noise,
                         output int lat, output int n_cs, output int n_strb,
                         output int strb_first, output int n_other, output int n_bad,
                         output logic [DW-1:0] rd_at_ack);
    lat = -1; n_cs = 0; n_strb = 0; strb_first = -1; n_other = 0; n_bad = 0;
    rd_at_ack = '0;
    req = 1'b1; we = t_we; addr = t_addr; wdata = t_wdata;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (noise && busy) begin
        req = 1'($urandom); soft_rst = 1'($urandom); we = 1'($urandom);
        addr = AW'($urandom); wdata = DW'($urandom);
      end else begin
        req = 1'b0; soft_rst = 1'b0;
      end
      if (!cs_n) begin
        n_cs++;
        if (otg_addr !== t_addr) n_bad++;
      end
      if (t_we ? !wr_n : !rd_n) begin
        n_strb++;
        if (strb_first < 0) strb_first = n_cs;
      end
      if (t_we ? !rd_n : !wr_n) n_other++;
      if (t_we && !cs_n) begin
        if (otg_data !== t_wdata) n_bad++;
      end else if (rd_n && !released()) n_bad++;
      if (ack) begin
        lat = c;
        rd_at_ack = rdata;
        break;
      end
    end
    req = 1'b0; soft_rst = 1'b0;
    if (lat < 0) begin
      vectors++; miscompares++;
      $display("FAIL txn_timeout: got no ack within 20 cycles, want ack at %0d", ExpLat);
    end
  endtask

  task automatic test_reset();
    Reset_N = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    soft_rst = 1'b0; otg_int = 1'b0;
    for (int i = 0; i < 4; i++) exp_mem[i] = '0;
    repeat (2) tick();
    vectors++;
    if ({busy, ack, cs_n, rd_n, wr_n, rst_n, irq_level, irq_pulse} !== 8'b0011_1000) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b want 00111000",
               {busy, ack, cs_n, rd_n, wr_n, rst_n, irq_level, irq_pulse});
    end
    vectors++;
    if (rdata !== '0 || otg_addr !== '0) begin
      miscompares++;
      $display("FAIL reset_regs: got rdata=%h addr=%h want 0/0", rdata, otg_addr);
    end
    vectors++;
    if (!released()) begin
      miscompares++;
      $display("FAIL reset_bus: got %h want high-Z", otg_data);
    end
    Reset_N = 1'b1;
    tick();
    vectors++;
    if (rst_n !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release: got rst_n=%b busy=%b want 1/0", rst_n, busy);
    end
  endtask

  task automatic test_write();
    int lat, n_cs, n_strb, sf, n_oth, n_bad;
    logic [DW-1:0] rd;
    run_txn(1'b1, 2'd2, 16'hA5A5, 1'b0, lat, n_cs, n_strb, sf, n_oth, n_bad, rd);
    exp_mem[2] = 16'hA5A5;
    vectors++;
    if (lat !== ExpLat) begin
      miscompares++; $display("FAIL write_latency: got %0d want %0d", lat, ExpLat);
    end
    vectors++;
    if (n_cs !== ExpCs) begin
      miscompares++; $display("FAIL write_cs_len: got %0d want %0d", n_cs, ExpCs);
    end
    vectors++;
    if (n_strb !== STC || sf !== SC + 1) begin
      miscompares++;
      $display("FAIL write_strobe: got len=%0d start=%0d want %0d/%0d", n_strb, sf, STC, SC + 1);
    end
    vectors++;
    if (n_oth !== 0 || n_bad !== 0) begin
      miscompares++;
      $display("FAIL write_bus: got rd_low=%0d bad=%0d want 0/0", n_oth, n_bad);
    end
    vectors++;
    if (slave_mem[2] !== exp_mem[2]) begin
      miscompares++; $display("FAIL write_slave: got %h want %h", slave_mem[2], exp_mem[2]);
    end
  endtask

  task automatic test_read();
    int lat, n_cs, n_strb, sf, n_oth, n_bad;
    logic [DW-1:0] rd;
    run_txn(1'b1, 2'd1, 16'h1234, 1'b0, lat, n_cs, n_strb, sf, n_oth, n_bad, rd);
    exp_mem[1] = 16'h1234;
    run_txn(1'b0, 2'd1, 16'h0000, 1'b0, lat, n_cs, n_strb, sf, n_oth, n_bad, rd);
    vectors++;
    if (lat !== ExpLat) begin
      miscompares++; $display("FAIL read_latency: got %0d want %0d", lat, ExpLat);
    end
    vectors++;
    if (n_strb !== STC || n_oth !== 0) begin
      miscompares++;
      $display("FAIL read_strobe: got rd_low=%0d wr_low=%0d want %0d/0", n_strb, n_oth, STC);
    end
    vectors++;
    if (n_bad !== 0) begin
      miscompares++; $display("FAIL read_bus: got %0d bad cycles want 0", n_bad);
    end
    vectors++;
    if (rd !== exp_mem[1]) begin
      miscompares++; $display("FAIL read_data: got %h want %h", rd, exp_mem[1]);
    end
    repeat (3) tick();
    vectors++;
    if (rdata !== exp_mem[1]) begin
      miscompares++; $display("FAIL read_hold: got %h want %h", rdata, exp_mem[1]);
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] d;
    int lat, n_cs;
    d = DW'($urandom_range(16'hFFFF, 1));
    req = 1'b1; we = 1'b1; addr = 2'd3; wdata = d;
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (ack) begin lat = c; break; end
    end
    exp_mem[3] = d;
    vectors++;
    if (lat !== ExpLat) begin
      miscompares++; $display("FAIL b2b_first_ack: got %0d want %0d", lat, ExpLat);
    end
    we = 1'b0;
    tick();
    req = 1'b0;
    vectors++;
    if (cs_n !== 1'b0) begin
      miscompares++; $display("FAIL b2b_gap: got cs_n=%b after ack want 0", cs_n);
    end
    n_cs = (cs_n === 1'b0) ? 1 : 0;
    lat = -1;
    for (int c = 2; c <= 20; c++) begin
      tick();
      if (!cs_n) n_cs++;
      if (ack) begin lat = c; break; end
    end
    vectors++;
    if (lat !== ExpLat || n_cs !== ExpCs) begin
      miscompares++;
      $display("FAIL b2b_second: got lat=%0d cs=%0d want %0d/%0d", lat, n_cs, ExpLat, ExpCs);
    end
    vectors++;
    if (rdata !== exp_mem[3]) begin
      miscompares++; $display("FAIL b2b_rdata: got %h want %h", rdata, exp_mem[3]);
    end
  endtask

  task automatic test_async_reset();
    int n_ack;
    req = 1'b1; we = 1'b1; addr = 2'd2; wdata = 16'h5AC3;
    tick();
    req = 1'b0;
    tick();
    vectors++;
    if (wr_n !== 1'b0) begin
      miscompares++; $display("FAIL arst_in_strobe: got wr_n=%b want 0", wr_n);
    end
    #2 Reset_N = 1'b0;
    #1;
    vectors++;
    if ({cs_n, rd_n, wr_n, busy, rst_n} !== 5'b11100) begin
      miscompares++;
      $display("FAIL arst_ctrl: got %b want 11100", {cs_n, rd_n, wr_n, busy, rst_n});
    end
    vectors++;
    if (!released() || rdata !== '0 || otg_addr !== '0) begin
      miscompares++;
      $display("FAIL arst_bus: got data=%h rdata=%h addr=%h want Z/0/0", otg_data, rdata, otg_addr);
    end
    repeat (2) tick();
    Reset_N = 1'b1;
    n_ack = 0;
    repeat (8) begin
      tick();
      if (ack) n_ack++;
    end
    vectors++;
    if (n_ack !== 0 || rst_n !== 1'b1) begin
      miscompares++;
      $display("FAIL arst_after: got acks=%0d rst_n=%b want 0/1", n_ack, rst_n);
    end
  endtask

  task automatic test_soft_rst();
    int n_rst, n_busy, n_cs, n_ack;
    req = 1'b1; we = 1'b1; addr = 2'd0; wdata = 16'hFFFF; soft_rst = 1'b1;
    tick();
    req = 1'b0; soft_rst = 1'b0;
    vectors++;
    if (rst_n !== 1'b0) begin
      miscompares++; $display("FAIL srst_start: got rst_n=%b want 0", rst_n);
    end
    n_rst = 0; n_busy = 0; n_cs = 0; n_ack = 0;
    repeat (12) begin
      if (!rst_n) n_rst++;
      if (busy) n_busy++;
      if (!cs_n) n_cs++;
      if (ack) n_ack++;
      tick();
    end
    vectors++;
    if (n_rst !== RC || n_busy !== RC) begin
      miscompares++;
      $display("FAIL srst_len: got rst=%0d busy=%0d want %0d/%0d", n_rst, n_busy, RC, RC);
    end
    vectors++;
    if (n_cs !== 0 || n_ack !== 0 || slave_mem[0] !== exp_mem[0]) begin
      miscompares++;
      $display("FAIL srst_drop: got cs=%0d ack=%0d mem0=%h want 0/0/%h",
               n_cs, n_ack, slave_mem[0], exp_mem[0]);
    end
  endtask

  task automatic test_random();
    int lat, n_cs, n_strb, sf, n_oth, n_bad;
    logic [DW-1:0] rd, d, last_rd;
    logic t_we;
    logic [AW-1:0] a;
    last_rd = '0;
    for (int i = 0; i < 40; i++) begin
      t_we = 1'($urandom); a = AW'($urandom); d = DW'($urandom);
      repeat ($urandom_range(2, 0)) tick();
      run_txn(t_we, a, d, 1'b1, lat, n_cs, n_strb, sf, n_oth, n_bad, rd);
      vectors++;
      if (lat !== ExpLat || n_cs !== ExpCs || n_strb !== STC) begin
        miscompares++;
        $display("FAIL rand_timing[%0d]: got lat=%0d cs=%0d strb=%0d want %0d/%0d/%0d",
                 i, lat, n_cs, n_strb, ExpLat, ExpCs, STC);
      end
      vectors++;
      if (n_bad !== 0 || n_oth !== 0) begin
        miscompares++;
        $display("FAIL rand_bus[%0d]: got bad=%0d other=%0d want 0/0", i, n_bad, n_oth);
      end
      if (t_we) exp_mem[a] = d;
      else last_rd = exp_mem[a];
      vectors++;
      if (rd !== last_rd) begin
        miscompares++;
        $display("FAIL rand_rdata[%0d]: got %h want %h (we=%b addr=%0d)", i, rd, last_rd, t_we, a);
      end
    end
  endtask

  task automatic test_irq();
    int n_pulse;
    otg_int = 1'b1;
    tick();
    n_pulse = irq_pulse ? 1 : 0;
    vectors++;
    if (irq_level !== 1'b0) begin
      miscompares++; $display("FAIL irq_early: got %b want 0", irq_level);
    end
    tick();
    if (irq_pulse) n_pulse++;
    vectors++;
    if (irq_level !== 1'b1) begin
      miscompares++; $display("FAIL irq_level: got %b want 1", irq_level);
    end
    repeat (8) begin
      tick();
      if (irq_pulse) n_pulse++;
    end
    otg_int = 1'b0;
    repeat (4) begin
      tick();
      if (irq_pulse) n_pulse++;
    end
    vectors++;
    if (n_pulse !== 1 || irq_level !== 1'b0) begin
      miscompares++;
      $display("FAIL irq_pulse: got pulses=%0d level=%b want 1/0", n_pulse, irq_level);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_async_reset();
    test_soft_rst();
    test_random();
    test_irq();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion by 1000000 want finish");
    $fatal(1);
  end

endmodule
